reg_bank_ctrl: RTL and testbench

REG_BANK_CTRL -- requirements
Module: reg_bank_ctrl

---
 rtl/reg_bank_ctrl.sv | 160 ++++++++++++++++
 tb/tb_reg_bank_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_ctrl.sv
// Register-bank access controller: round-robin arbitration between two requesters
// and a one-hot initial-value load sweep, all outputs registered.
module reg_bank_ctrl #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start_ini,
    output logic [NREG-1:0]   o_ini_en,
    output logic              o_ini_busy,
    output logic              o_ini_done,
    input  logic              i_a_req,
    input  logic              i_b_req,
    input  logic              i_a_wr,
    input  logic              i_b_wr,
    input  logic [AW-1:0]     i_a_addr,
    input  logic [AW-1:0]     i_b_addr,
    input  logic [7:0]        i_a_wdat,
    input  logic [7:0]        i_b_wdat,
    output logic              o_a_gnt,
    output logic              o_b_gnt,
    output logic              o_a_rvld,
    output logic              o_b_rvld,
    output logic [7:0]        o_rdat,
    output logic [NREG-1:0]   o_cs,
    output logic [7:0]        o_wdat,
    input  logic [NREG*8-1:0] i_reg
);

    typedef enum logic [1:0] {IDLE, INIT, ACC, RESP} state_t;

    localparam logic [NREG-1:0] ONE = NREG'(1);

    state_t          state_q;
    logic            pend_q;
    logic            last_b_q;
    logic            sel_b_q;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [NREG-1:0] ini_en_q;
    logic            busy_q;
    logic            done_q;
    logic            a_gnt_q;
    logic            b_gnt_q;
    logic            a_rvld_q;
    logic            b_rvld_q;
    logic [7:0]      rdat_q;
    logic [NREG-1:0] cs_q;
    logic [7:0]      wdat_q;

    logic            win_b_d;
    logic            wr_d;
    logic [AW-1:0]   addr_d;
    logic [7:0]      wdat_d;
    logic [NREG-1:0] cs_d;
    logic [7:0]      rdat_d;

    // B wins only if A is idle or A was the last one served.
    always_comb begin
        win_b_d = i_b_req & (~i_a_req | ~last_b_q);
        wr_d    = win_b_d ? i_b_wr   : i_a_wr;
        addr_d  = win_b_d ? i_b_addr : i_a_addr;
        wdat_d  = win_b_d ? i_b_wdat : i_a_wdat;
        cs_d    = '0;
        rdat_d  = 8'h00;
        for (int k = 0; k < NREG; k++) begin
            if (int'(addr_d) == k) cs_d[k] = 1'b1;
            if (int'(addr_q) == k) rdat_d = i_reg[8*k +: 8];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            last_b_q <= 1'b1;
            sel_b_q  <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            ini_en_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_gnt_q  <= 1'b0;
            b_gnt_q  <= 1'b0;
            a_rvld_q <= 1'b0;
            b_rvld_q <= 1'b0;
            rdat_q   <= 8'h00;
            cs_q     <= '0;
            wdat_q   <= 8'h00;
        end else begin
            a_gnt_q  <= 1'b0;
            b_gnt_q  <= 1'b0;
            a_rvld_q <= 1'b0;
            b_rvld_q <= 1'b0;
            done_q   <= 1'b0;
            cs_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (pend_q || i_start_ini) begin
                        state_q  <= INIT;
                        pend_q   <= 1'b0;
                        ini_en_q <= ONE;
                        busy_q   <= 1'b1;
                    end else if (i_a_req || i_b_req) begin
                        state_q  <= ACC;
                        sel_b_q  <= win_b_d;
                        last_b_q <= win_b_d;
                        wr_q     <= wr_d;
                        addr_q   <= addr_d;
                        a_gnt_q  <= ~win_b_d;
                        b_gnt_q  <= win_b_d;
                        if (wr_d) begin
                            cs_q   <= cs_d;
                            wdat_q <= wdat_d;
                        end
                    end
                end
                INIT: begin
                    if (ini_en_q[NREG-1]) begin
                        state_q  <= IDLE;
                        ini_en_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        ini_en_q <= ini_en_q << 1;
                    end
                end
                ACC: begin
                    pend_q <= pend_q | i_start_ini;
                    if (wr_q) begin
                        state_q <= IDLE;
                    end else begin
                        state_q  <= RESP;
                        rdat_q   <= rdat_d;
                        a_rvld_q <= ~sel_b_q;
                        b_rvld_q <= sel_b_q;
                    end
                end
                RESP: begin
                    pend_q  <= pend_q | i_start_ini;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ini_en   = ini_en_q;
    assign o_ini_busy = busy_q;
    assign o_ini_done = done_q;
    assign o_a_gnt    = a_gnt_q;
    assign o_b_gnt    = b_gnt_q;
    assign o_a_rvld   = a_rvld_q;
    assign o_b_rvld   = b_rvld_q;
    assign o_rdat     = rdat_q;
    assign o_cs       = cs_q;
    assign o_wdat     = wdat_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Scoreboard bench for reg_bank_ctrl: an 8-register instance and a 6-register
// instance for the out-of-range address cases.
module tb_reg_bank_ctrl;

    localparam logic [2:0] EV_GA = 3'd0, EV_GB = 3'd1, EV_RA = 3'd2, EV_RB = 3'd3,
                           EV_IE = 3'd4, EV_ID = 3'd5, EV_NONE = 3'd7;

    typedef struct packed {
        logic [2:0] k;
        logic [7:0] d;
        logic [7:0] w;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_ini = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0, a_wr = 1'b0, b_wr = 1'b0;
    logic [2:0]  a_addr = '0, b_addr = '0;
    logic [7:0]  a_wdat = '0, b_wdat = '0;
    logic [63:0] regs8 = 64'hF01EC34B962D780F;
    logic [7:0]  ini_en, cs;
    logic        busy, done, a_gnt, b_gnt, a_rvld, b_rvld;
    logic [7:0]  rdat, wdat;

    logic        a6_req = 1'b0, a6_wr = 1'b0, zero1 = 1'b0;
    logic [2:0]  a6_addr = '0, zero3 = '0;
    logic [7:0]  a6_wdat = '0, zero8 = '0;
    logic [47:0] regs6 = 48'h1EC34B962D78;
    logic [5:0]  ini_en6, cs6;
    logic        busy6, done6, a6_gnt, b6_gnt, a6_rvld, b6_rvld;
    logic [7:0]  rdat6, wdat6;

    reg_bank_ctrl #(.NREG(8), .AW(3)) u8 (
        .i_clk(clk), .i_rst(rst), .i_start_ini(start_ini),
        .o_ini_en(ini_en), .o_ini_busy(busy), .o_ini_done(done),
        .i_a_req(a_req), .i_b_req(b_req), .i_a_wr(a_wr), .i_b_wr(b_wr),
        .i_a_addr(a_addr), .i_b_addr(b_addr), .i_a_wdat(a_wdat), .i_b_wdat(b_wdat),
        .o_a_gnt(a_gnt), .o_b_gnt(b_gnt), .o_a_rvld(a_rvld), .o_b_rvld(b_rvld),
        .o_rdat(rdat), .o_cs(cs), .o_wdat(wdat), .i_reg(regs8)
    );

    reg_bank_ctrl #(.NREG(6), .AW(3)) u6 (
        .i_clk(clk), .i_rst(rst), .i_start_ini(zero1),
        .o_ini_en(ini_en6), .o_ini_busy(busy6), .o_ini_done(done6),
        .i_a_req(a6_req), .i_b_req(zero1), .i_a_wr(a6_wr), .i_b_wr(zero1),
        .i_a_addr(a6_addr), .i_b_addr(zero3), .i_a_wdat(a6_wdat), .i_b_wdat(zero8),
        .o_a_gnt(a6_gnt), .o_b_gnt(b6_gnt), .o_a_rvld(a6_rvld), .o_b_rvld(b6_rvld),
        .o_rdat(rdat6), .o_cs(cs6), .o_wdat(wdat6), .i_reg(regs6)
    );

    ev_t q8[$];
    ev_t q6[$];
    ev_t o8, o6;
    int  n_vec = 0;
    int  n_err = 0;

    function automatic ev_t mk(input logic [2:0] k, input logic [7:0] d, input logic [7:0] w);
        ev_t e;
        e.k = k; e.d = d; e.w = w;
        return e;
    endfunction

    function automatic ev_t observe(input logic ag, input logic bg, input logic ar, input logic br,
                                    input logic [7:0] ien, input logic dn, input logic bz,
                                    input logic [7:0] c, input logic [7:0] wd, input logic [7:0] rd);
        if (ag)        return mk(EV_GA, c, wd);
        if (bg)        return mk(EV_GB, c, wd);
        if (ar)        return mk(EV_RA, rd, 8'h00);
        if (br)        return mk(EV_RB, rd, 8'h00);
        if (ien != 0)  return mk(EV_IE, ien, {7'b0, bz});
        if (dn)        return mk(EV_ID, 8'h00, {7'b0, bz});
        return mk(EV_NONE, 8'h00, 8'h00);
    endfunction

    task automatic cmp(input string tag, input ev_t got, input ev_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got kind=%0d d=%h w=%h, expected kind=%0d d=%h w=%h",
                     tag, got.k, got.d, got.w, exp.k, exp.d, exp.w);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Monitors: every cycle that presents an output event consumes one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            o8 = observe(a_gnt, b_gnt, a_rvld, b_rvld, ini_en, done, busy, cs, wdat, rdat);
            if (o8.k != EV_NONE) begin
                if (q8.size() == 0) cmp("dut8 unexpected event", o8, mk(EV_NONE, 8'h00, 8'h00));
                else                cmp("dut8 event", o8, q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            o6 = observe(a6_gnt, b6_gnt, a6_rvld, b6_rvld, {2'b0, ini_en6}, done6, busy6,
                         {2'b0, cs6}, wdat6, rdat6);
            if (o6.k != EV_NONE) begin
                if (q6.size() == 0) cmp("dut6 unexpected event", o6, mk(EV_NONE, 8'h00, 8'h00));
                else                cmp("dut6 event", o6, q6.pop_front());
            end
        end
    end

    task automatic chk_reset_state();
        chk("dut8 reset outputs", {26'b0, ini_en, busy, done, a_gnt, b_gnt, a_rvld, b_rvld, rdat, cs, wdat}, 64'h0);
        chk("dut6 reset outputs", {30'b0, ini_en6, busy6, done6, a6_gnt, b6_gnt, a6_rvld, b6_rvld, rdat6, cs6, wdat6}, 64'h0);
    endtask

    task automatic access(input bit d6, input bit b, input logic wr, input logic [2:0] addr, input logic [7:0] wd);
        bit seen = 1'b0;
        @(posedge clk); #1;
        if (d6)     begin a6_req = 1'b1; a6_wr = wr; a6_addr = addr; a6_wdat = wd; end
        else if (b) begin b_req  = 1'b1; b_wr  = wr; b_addr  = addr; b_wdat  = wd; end
        else        begin a_req  = 1'b1; a_wr  = wr; a_addr  = addr; a_wdat  = wd; end
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = d6 ? a6_gnt : (b ? b_gnt : a_gnt);
        end
        if (!seen) chk("grant timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        a6_req = 1'b0; a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic wait_drain(input bit d6);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if ((d6 ? q6.size() : q8.size()) == 0) break;
        end
        chk(d6 ? "dut6 pending expectations" : "dut8 pending expectations",
            64'(d6 ? q6.size() : q8.size()), 64'd0);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 8; i++) q8.push_back(mk(EV_IE, 8'(1 << i), 8'h01));
        q8.push_back(mk(EV_ID, 8'h00, 8'h00));
    endtask

    initial begin
        int  n;
        bit  seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        @(posedge clk); #1 rst = 1'b0;

        // One-cycle init request walks the enables 0x01..0x80, then done.
        push_sweep();
        @(posedge clk); #1 start_ini = 1'b1;
        @(posedge clk); #1 start_ini = 1'b0;
        wait_drain(1'b0);

        q8.push_back(mk(EV_GA, 8'h08, 8'h5A));
        access(1'b0, 1'b0, 1'b1, 3'd3, 8'h5A);
        wait_drain(1'b0);

        q8.push_back(mk(EV_GB, 8'h00, 8'h5A));
        q8.push_back(mk(EV_RB, 8'hC3, 8'h00));
        access(1'b0, 1'b1, 1'b0, 3'd5, 8'h00);
        wait_drain(1'b0);

        q8.push_back(mk(EV_GA, 8'h00, 8'h5A));
        q8.push_back(mk(EV_RA, 8'h0F, 8'h00));
        access(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
        wait_drain(1'b0);

        q8.push_back(mk(EV_GB, 8'h80, 8'hE7));
        access(1'b0, 1'b1, 1'b1, 3'd7, 8'hE7);
        wait_drain(1'b0);

        // Both requesters held high from reset: A first, then strict alternation.
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk_reset_state();
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q8.push_back(mk(EV_GA, 8'h02, 8'h11));
            q8.push_back(mk(EV_GB, 8'h04, 8'h22));
        end
        a_wr = 1'b1; a_addr = 3'd1; a_wdat = 8'h11;
        b_wr = 1'b1; b_addr = 3'd2; b_wdat = 8'h22;
        a_req = 1'b1; b_req = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (a_gnt || b_gnt) n++;
        end
        chk("round-robin grant count", 64'(n), 64'd6);
        @(posedge clk); #1 a_req = 1'b0; b_req = 1'b0;
        wait_drain(1'b0);

        // Init requested during A's access: A completes, sweep runs, then B is served.
        q8.push_back(mk(EV_GA, 8'h10, 8'h44));
        push_sweep();
        q8.push_back(mk(EV_GB, 8'h00, 8'h44));
        q8.push_back(mk(EV_RB, 8'hC3, 8'h00));
        @(posedge clk); #1;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 3'd4; a_wdat = 8'h44;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = a_gnt;
        end
        if (!seen) chk("init-during-access A grant timeout", 64'd0, 64'd1);
        start_ini = 1'b1;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 3'd5;
        @(posedge clk); #1 start_ini = 1'b0; a_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = b_gnt;
        end
        if (!seen) chk("init-during-access B grant timeout", 64'd0, 64'd1);
        @(posedge clk); #1 b_req = 1'b0;
        wait_drain(1'b0);

        // Reset in the middle of a sweep: no further enables and no done pulse.
        q8.push_back(mk(EV_IE, 8'h01, 8'h01));
        q8.push_back(mk(EV_IE, 8'h02, 8'h01));
        q8.push_back(mk(EV_IE, 8'h04, 8'h01));
        @(posedge clk); #1 start_ini = 1'b1;
        @(posedge clk); #1 start_ini = 1'b0;
        wait_drain(1'b0);
        rst = 1'b1;
        #1 chk_reset_state();
        @(posedge clk); #1 rst = 1'b0;
        repeat (12) @(posedge clk);

        // Reset during a read's grant cycle: no read-valid follows.
        q8.push_back(mk(EV_GA, 8'h00, 8'h00));
        @(posedge clk); #1;
        a_req = 1'b1; a_wr = 1'b0; a_addr = 3'd2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = a_gnt;
        end
        if (!seen) chk("abort-read grant timeout", 64'd0, 64'd1);
        #1 rst = 1'b1; a_req = 1'b0;
        #1 chk_reset_state();
        @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        chk("dut8 abort-read leftover", 64'(q8.size()), 64'd0);

        // Six-register instance: addresses 6 and 7 are out of range.
        q6.push_back(mk(EV_GA, 8'h00, 8'h00));
        q6.push_back(mk(EV_RA, 8'h00, 8'h00));
        access(1'b1, 1'b0, 1'b0, 3'd7, 8'h00);
        q6.push_back(mk(EV_GA, 8'h00, 8'h66));
        access(1'b1, 1'b0, 1'b1, 3'd6, 8'h66);
        q6.push_back(mk(EV_GA, 8'h20, 8'h55));
        access(1'b1, 1'b0, 1'b1, 3'd5, 8'h55);
        q6.push_back(mk(EV_GA, 8'h00, 8'h55));
        q6.push_back(mk(EV_RA, 8'h1E, 8'h00));
        access(1'b1, 1'b0, 1'b0, 3'd5, 8'h00);
        wait_drain(1'b1);

        repeat (4) @(posedge clk);
        chk("dut8 final queue", 64'(q8.size()), 64'd0);
        chk("dut6 final queue", 64'(q6.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
